nibble_adder_sequencer: RTL and testbench
=========================================

Name: nibble_adder_sequencer

Overview:
Multi-cycle controller that adds two WIDTH-bit operands by driving one external 4-bit gate-level adder slice (ripple-carry or look-ahead) a nibble at a time, LSB first. It sits directly upstream of the 4-bit adder: it feeds the adder's A/B/C_in and consumes its S/C_out after a programmable settle time. A registered carry links the nibbles. This lets the team compare RCA and LACA slices at system level by sweeping SETTLE_CYCLES.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
SETTLE_CYCLES, 5, clock cycles each nibble is held on the adder before S/C_out are sampled; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; accepted only in IDLE.
a  input  WIDTH  operand A; sampled on the accepting edge.
b  input  WIDTH  operand B; sampled on the accepting edge.
c_in  input  1  carry into nibble 0; sampled on the accepting edge.
busy  output  1  high while nibbles are being processed.
done  output  1  one-cycle pulse; sum and c_out are valid.
sum  output  WIDTH  result.
c_out  output  1  carry out of the top nibble.
add_a  output  4  to adder A.
add_b  output  4  to adder B.
add_cin  output  1  to adder C_in.
add_s  input  4  from adder S.
add_cout  input  1  from adder C_out.

Behaviour:
- Reset (async assert, sync release) drives: state IDLE; busy, done, c_out, add_a, add_b, add_cin = 0; sum = 0; nibble index, settle counter, carry register and operand registers = 0.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> RUN between nibbles.
  - RUN -> DONE after the last nibble is sampled.
  - DONE -> IDLE unconditionally after one cycle.
- Accept: on edge k in IDLE with start=1:
  - latch a, b into shift registers;
  - carry register <= c_in;
  - index <= 0; settle counter <= 0;
  - busy = 1 from edge k.
- RUN:
  - add_a/add_b = low nibble of the operand shift registers; add_cin = carry register. All are registered or decoded from registers, so they are glitch-free and constant while the counter runs.
  - The counter increments each cycle. When it equals SETTLE_CYCLES-1, the next edge:
    - shifts add_s into the top of the sum shift register (sum shifts right by 4);
    - carry register <= add_cout;
    - shifts the operand registers right by 4;
    - index++ and counter <= 0.
- Last nibble: the sampling edge with index = WIDTH/4-1 moves to DONE and sets c_out <= add_cout.
- Latency: nibble i is sampled at edge k+(i+1)*SETTLE_CYCLES. done is high in the cycle following edge k+(WIDTH/4)*SETTLE_CYCLES. busy falls on that same edge. busy and done are never high together.
- add_a, add_b, add_cin = 0 in IDLE and DONE.
- sum and c_out hold their value from DONE through IDLE until the next accept. During RUN they are partial and must not be used.
- start is ignored in RUN and DONE; no queuing. The earliest next accept is the cycle after done, i.e. the first IDLE cycle.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1).
- Overflow and wrap: the nibble carry propagates through the register, so a full-width ripple such as FFFF+1 must carry correctly across nibbles.
- Reset mid-RUN: abort immediately, all state to reset values, no done pulse.
- start held high continuously: one operation per IDLE visit.
- Parameter violation (WIDTH%4≠0, WIDTH<4, SETTLE_CYCLES<1): elaboration-time error.

Decomposition:
- Shared package adder_seq_pkg holds:
  - NIBBLE_W = 4;
  - state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the helper function num_nibbles(width) = width/4.
- Sub-module settle_timer is natural. It is a cycles-wide counter with clear and a terminal-count output, reused by the later LACA comparison harness.

Test Plan:
- WIDTH=16, SETTLE_CYCLES=5, RCA slice instanced in bench; a=16'h1234, b=16'h4321, c_in=0 -> done 20 cycles after accept, sum=16'h5555, c_out=0.
- a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, c_out=1. Then a=16'hFFFF, b=16'h0000, c_in=1 -> sum=16'h0000, c_out=1; add_cin=1 observed on every nibble.
- start pulsed in cycles 3 and 12 of a RUN (a=16'h00FF, b=16'h0001) -> ignored; single done, sum=16'h0100. Re-start in the first IDLE cycle after done is accepted.
- rst_n low at cycle 7 of RUN -> busy, done, sum, c_out, add_* all 0 immediately; no done pulse. A fresh op afterwards is correct.
- SETTLE_CYCLES=1, WIDTH=4: a=4'hA, b=4'h5, c_in=1 -> done one cycle after accept edge + 1, sum=4'h0, c_out=1. SETTLE_CYCLES too small for the RCA gate delay -> bench checks the wrong result, demonstrating settle dependency.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer and its helpers.
package adder_seq_pkg;

  localparam int NIBBLE_W = 4;

  // Controller state encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Number of 4-bit slices needed to cover an operand of the given width.
  function automatic int num_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_adder_sequencer_settle_timer.sv
// Settle timer: counts held cycles and flags the last one before sampling.
module settle_timer #(
  parameter int CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_r;

  assign tc = (cnt_r == CNT_W'(CYCLES - 1));

  // Counter: cleared on request, wraps to zero after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      if (tc) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/nibble_adder_sequencer.sv
// Nibble-serial adder controller: drives an external 4-bit adder slice LSB
// nibble first, holding each nibble SETTLE_CYCLES before sampling S/C_out.
module nibble_adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
);

  localparam int NIBBLES = num_nibbles(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W) || (SETTLE_CYCLES < 1)) begin : g_param_check
    $error("nibble_adder_sequencer: WIDTH must be a multiple of 4 (>=4) and SETTLE_CYCLES >= 1");
  end

  logic [1:0]         state_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               c_out_r;
  logic               busy_r;
  logic               done_r;
  logic [IDX_W-1:0]   idx_r;
  logic               tmr_clr_s;
  logic               tmr_en_s;
  logic               tmr_tc_s;
  logic [WIDTH+3:0]   sum_cat_s;
  logic [WIDTH-1:0]   sum_next_s;

  // The freshly sampled nibble enters at the top; the sum shifts right.
  assign sum_cat_s  = {add_s, sum_r};
  assign sum_next_s = sum_cat_s[WIDTH+3:NIBBLE_W];

  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign c_out = c_out_r;

  // Timer control: restart on accept, run only while nibbles are in flight.
  always_comb begin
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
    case (state_r)
      IDLE:    tmr_clr_s = start;
      RUN:     tmr_en_s  = 1'b1;
      default: begin
        tmr_clr_s = 1'b0;
        tmr_en_s  = 1'b0;
      end
    endcase
  end

  settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr_s),
    .en    (tmr_en_s),
    .tc    (tmr_tc_s)
  );

  // Adder drive decoded from registers only; quiet outside RUN.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_r == RUN) begin
      add_a   = a_sh_r[NIBBLE_W-1:0];
      add_b   = b_sh_r[NIBBLE_W-1:0];
      add_cin = carry_r;
    end else begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
    end
  end

  // Sequencer FSM with operand/sum shift registers and the nibble carry link.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= c_in;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          if (tmr_tc_s) begin
            sum_r   <= sum_next_s;
            carry_r <= add_cout;
            a_sh_r  <= a_sh_r >> NIBBLE_W;
            b_sh_r  <= b_sh_r >> NIBBLE_W;
            if (idx_r == IDX_W'(NIBBLES - 1)) begin
              c_out_r <= add_cout;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_adder_sequencer.sv
// Directed bench: a 16-bit sequencer on a 4-cycle ripple slice, a 4-bit
// sequencer on an instantaneous slice, and a 4-bit sequencer whose settle
// time is shorter than its slice delay.
module tb_nibble_adder_sequencer;

  logic clk;
  logic rst_n;

  logic        start16, cin16, busy16, done16, c_out16, add_cin16, add_cout16;
  logic [15:0] a16, b16, sum16;
  logic [3:0]  add_a16, add_b16, add_s16;

  logic        start4, cin4, busy4, done4, c_out4, add_cin4, add_cout4;
  logic [3:0]  a4, b4, sum4, add_a4, add_b4, add_s4;

  logic        start_sl, cin_sl, busy_sl, done_sl, c_out_sl, add_cin_sl, add_cout_sl;
  logic [3:0]  a_sl, b_sl, sum_sl, add_a_sl, add_b_sl, add_s_sl;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_adder_sequencer #(.WIDTH(16), .SETTLE_CYCLES(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .c_in(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(c_out16),
    .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16),
    .add_s(add_s16), .add_cout(add_cout16)
  );

  nibble_adder_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_s(add_s4), .add_cout(add_cout4)
  );

  nibble_adder_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) dut_slow (
    .clk(clk), .rst_n(rst_n), .start(start_sl), .a(a_sl), .b(b_sl), .c_in(cin_sl),
    .busy(busy_sl), .done(done_sl), .sum(sum_sl), .c_out(c_out_sl),
    .add_a(add_a_sl), .add_b(add_b_sl), .add_cin(add_cin_sl),
    .add_s(add_s_sl), .add_cout(add_cout_sl)
  );

  // Ripple slice for dut16: result appears 4 clocks after its inputs settle.
  logic [4:0] rca_comb_s;
  logic [4:0] rca_pipe_r [4];
  assign rca_comb_s = {1'b0, add_a16} + {1'b0, add_b16} + {4'b0000, add_cin16};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) rca_pipe_r[i] <= 5'd0;
    end else begin
      rca_pipe_r[0] <= rca_comb_s;
      for (int i = 1; i < 4; i++) rca_pipe_r[i] <= rca_pipe_r[i-1];
    end
  end
  assign add_s16    = rca_pipe_r[3][3:0];
  assign add_cout16 = rca_pipe_r[3][4];

  // Instantaneous slice for dut4.
  assign {add_cout4, add_s4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0000, add_cin4};

  // One-clock slice for dut_slow: too slow for SETTLE_CYCLES=1.
  logic [4:0] slow_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) slow_r <= 5'd0;
    else        slow_r <= {1'b0, add_a_sl} + {1'b0, add_b_sl} + {4'b0000, add_cin_sl};
  end
  assign add_s_sl    = slow_r[3:0];
  assign add_cout_sl = slow_r[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One 16-bit operation; start is re-pulsed in RUN cycles p1/p2 (0 = none).
  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       input int p1, input int p2,
                       output int lat, output int nocin, output int overlap);
    lat = -1; nocin = 0; overlap = 0;
    a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy16 && !add_cin16) nocin++;
      start16 = ((c == p1) || (c == p2));
      @(posedge clk); #1;
      start16 = 1'b0;
      if (busy16 && done16) overlap++;
      if (done16) begin
        lat = c;
        break;
      end
    end
    start16 = 1'b0;
  endtask

  int lat, nocin, overlap, ndone;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    start_sl = 1'b0; a_sl = 4'h0; b_sl = 4'h0; cin_sl = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ctrl", {30'd0, busy16, done16}, 32'd0);
    chk("reset_sum", {15'd0, c_out16, sum16}, 32'd0);
    chk("reset_adder", {23'd0, add_a16, add_b16, add_cin16}, 32'd0);

    // Basic add and latency.
    run16(16'h1234, 16'h4321, 1'b0, 0, 0, lat, nocin, overlap);
    chk("basic_lat", lat, 32'd20);
    chk("basic_sum", {15'd0, c_out16, sum16}, {15'd0, 1'b0, 16'h5555});
    chk("basic_overlap", overlap, 32'd0);
    @(posedge clk); #1;
    chk("idle_hold", {15'd0, c_out16, sum16}, {15'd0, 1'b0, 16'h5555});
    chk("idle_adder", {23'd0, add_a16, add_b16, add_cin16}, 32'd0);

    // Full-width ripple.
    run16(16'hFFFF, 16'h0001, 1'b0, 0, 0, lat, nocin, overlap);
    chk("ripple_sum", {15'd0, c_out16, sum16}, {15'd0, 1'b1, 16'h0000});
    @(posedge clk); #1;

    // Carry-in ripple: the slice carry-in must be 1 on every nibble.
    run16(16'hFFFF, 16'h0000, 1'b1, 0, 0, lat, nocin, overlap);
    chk("cin_sum", {15'd0, c_out16, sum16}, {15'd0, 1'b1, 16'h0000});
    chk("cin_every_nibble", nocin, 32'd0);
    @(posedge clk); #1;

    // start pulses during RUN are ignored; re-start in first IDLE cycle.
    run16(16'h00FF, 16'h0001, 1'b0, 3, 12, lat, nocin, overlap);
    chk("ignore_lat", lat, 32'd20);
    chk("ignore_sum", {15'd0, c_out16, sum16}, {15'd0, 1'b0, 16'h0100});
    @(posedge clk); #1;
    run16(16'hABCD, 16'h1111, 1'b0, 0, 0, lat, nocin, overlap);
    chk("restart_lat", lat, 32'd20);
    chk("restart_sum", {15'd0, c_out16, sum16}, {15'd0, 1'b0, 16'hBCDE});
    @(posedge clk); #1;

    // Reset in RUN cycle 7 aborts immediately.
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, busy16}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {30'd0, busy16, done16}, 32'd0);
    chk("abort_sum", {15'd0, c_out16, sum16}, 32'd0);
    chk("abort_adder", {23'd0, add_a16, add_b16, add_cin16}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst_n = 1'b1;
      if (done16) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    run16(16'h8001, 16'h8FFF, 1'b1, 0, 0, lat, nocin, overlap);
    chk("post_abort_lat", lat, 32'd20);
    chk("post_abort_sum", {15'd0, c_out16, sum16}, {15'd0, 1'b1, 16'h1001});
    @(posedge clk); #1;

    // 4-bit, one settle cycle, instantaneous slice.
    a4 = 4'hA; b4 = 4'h5; cin4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("w4_busy", {31'd0, busy4}, 32'd1);
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (done4) begin
        lat = c;
        break;
      end
    end
    chk("w4_lat", lat, 32'd1);
    chk("w4_sum", {27'd0, c_out4, sum4}, {27'd0, 1'b1, 4'h0});

    // Settle time shorter than slice delay samples the stale idle result.
    a_sl = 4'h3; b_sl = 4'h4; cin_sl = 1'b0; start_sl = 1'b1;
    @(posedge clk); #1;
    start_sl = 1'b0;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (done_sl) begin
        lat = c;
        break;
      end
    end
    chk("slow_lat", lat, 32'd1);
    chk("slow_wrong_sum", {27'd0, c_out_sl, sum_sl}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
